mmu_mem_arb: RTL and testbench
==============================

MMU_MEM_ARB -- requirements
Module: mmu_mem_arb

Interface
REQ-001 The block SHALL have parameter ACC_BIT, default 6: PTE accessed-bit position.
REQ-002 The block SHALL have parameter DIRTY_BIT, default 7: PTE dirty-bit position.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, all state on posedge
- reset  in  1  synchronous, active-high
- walk_req_valid  in  1  one-cycle walker PTE read pulse
- walk_req_addr  in  `PA_WIDTH  walker PTE address
- walk_rsp_valid  out  1  walker read data valid, one-cycle pulse
- walk_rsp_data  out  64  PTE read data
- mark_valid  in  1  one-cycle pulse requesting A/D update
- mark_accessed  in  1  set accessed bit
- mark_dirty  in  1  set dirty bit
- mark_addr  in  64  PTE address; bits [`PA_WIDTH-1:0] used
- mark_rsp_valid  out  1  A/D update complete, one-cycle pulse
- io_req_valid  in  1  secondary client request, held until accepted
- io_req_ready  out  1  io request accepted this cycle
- io_req_store  in  1  1 = store, 0 = load
- io_req_addr  in  `PA_WIDTH  io address
- io_req_data  in  64  io store data
- io_rsp_valid  out  1  io load data or store ack, one-cycle pulse
- io_rsp_data  out  64  io load data
- mem_req_valid  out  1  memory request, one-cycle pulse
- mem_req_addr  out  `PA_WIDTH  memory address
- mem_req_store  out  1  memory write
- mem_req_data  out  64  memory write data
- mem_rsp_valid  in  1  memory read data or write ack
- mem_rsp_data  in  64  memory read data
- arb_state  out  3  current FSM state encoding

Function
REQ-004 The block SHALL capture walk_req_valid and mark_valid pulses into pending flags (with address/bits) whenever they arrive, including while busy; one pending entry per source, a second pulse before service overwrites it.
REQ-005 At most one memory transaction SHALL be outstanding; mem_req_valid SHALL be a registered single-cycle pulse.
REQ-006 FSM states SHALL be IDLE, WALK_RD, IO_ACC, MARK_RD, MARK_WR.
REQ-007 In IDLE, priority SHALL be: pending mark, then walker/io by round-robin; the rr bit SHALL favour io after a walker grant and the walker after an io grant; reset value favours walker.
REQ-008 A grant in IDLE SHALL drive mem_req_valid the next cycle and clear the granted pending flag; io_req_ready SHALL pulse in the grant cycle.
REQ-009 WALK_RD: on mem_rsp_valid, next cycle walk_rsp_valid=1, walk_rsp_data=mem_rsp_data; return to IDLE.
REQ-010 IO_ACC: on mem_rsp_valid, next cycle io_rsp_valid=1, io_rsp_data=mem_rsp_data (0 for stores); return to IDLE.
REQ-011 MARK_RD: on mem_rsp_valid compute new = data | (accessed<<ACC_BIT) | (dirty<<(DIRTY_BIT and ACC_BIT)); dirty implies accessed.
REQ-012 If new == data, the block SHALL skip the write, pulse mark_rsp_valid next cycle, return to IDLE.
REQ-013 Otherwise the block SHALL issue a store of new to the same address next cycle, enter MARK_WR, and on mem_rsp_valid pulse mark_rsp_valid next cycle and return to IDLE.
REQ-014 mem_rsp_valid in IDLE SHALL be ignored.
REQ-015 Total latency, IDLE-to-response with zero-cycle memory latency: request pulse +1, response pulse mem_rsp+1.
REQ-016 Simultaneous walker and mark pulses SHALL both be captured; mark served first.

Reset
REQ-017 On reset all outputs SHALL be 0, state IDLE, pending flags clear, rr favours walker; reset mid-transaction abandons it with no response pulse, and later mem_rsp_valid is dropped.

Verification
REQ-018 Walker read 0x1000, mem returns 0x2000_0001 after 3 cycles -> one mem_req (addr 0x1000, store 0), walk_rsp_data 0x2000_0001 one cycle after mem_rsp.
REQ-019 Mark accessed at 0x2008, PTE 0x0F -> read, store 0x4F to 0x2008, single mark_rsp_valid after write ack.
REQ-020 Mark dirty at 0x2010, PTE 0xCF -> read only, no store, mark_rsp_valid one cycle after read rsp.
REQ-021 io load held valid continuously plus walker pulses every transaction -> grants alternate walker, io, walker; io never starves.
REQ-022 Mark and walker pulse same cycle while io busy -> order io rsp, mark (RMW), walker read.
REQ-023 Reset asserted in MARK_WR, stray mem_rsp_valid after -> no mark_rsp_valid, state IDLE, outputs 0.

Source files
------------

// File: rtl/mmu_mem_arb.sv
// Single-port memory arbiter shared by the page-table walker, the A/D-bit
// updater (read-modify-write of a PTE) and a secondary io client.
`ifndef PA_WIDTH
`define PA_WIDTH 56
`endif

module mmu_mem_arb #(
  parameter int ACC_BIT   = 6,
  parameter int DIRTY_BIT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 walk_req_valid,
  input  logic [`PA_WIDTH-1:0] walk_req_addr,
  output logic                 walk_rsp_valid,
  output logic [63:0]          walk_rsp_data,
  input  logic                 mark_valid,
  input  logic                 mark_accessed,
  input  logic                 mark_dirty,
  input  logic [63:0]          mark_addr,
  output logic                 mark_rsp_valid,
  input  logic                 io_req_valid,
  output logic                 io_req_ready,
  input  logic                 io_req_store,
  input  logic [`PA_WIDTH-1:0] io_req_addr,
  input  logic [63:0]          io_req_data,
  output logic                 io_rsp_valid,
  output logic [63:0]          io_rsp_data,
  output logic                 mem_req_valid,
  output logic [`PA_WIDTH-1:0] mem_req_addr,
  output logic                 mem_req_store,
  output logic [63:0]          mem_req_data,
  input  logic                 mem_rsp_valid,
  input  logic [63:0]          mem_rsp_data,
  output logic [2:0]           arb_state
);

  localparam int PA = `PA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WALK_RD = 3'd1,
    S_IO_ACC  = 3'd2,
    S_MARK_RD = 3'd3,
    S_MARK_WR = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Pending capture for the pulse-only clients (one entry each, newest wins).
  logic          walk_pend_q;
  logic [PA-1:0] walk_pend_addr_q;
  logic          mark_pend_q;
  logic [PA-1:0] mark_pend_addr_q;
  logic          mark_pend_acc_q;
  logic          mark_pend_dirty_q;

  // Round-robin pointer: 1 favours io, 0 favours the walker.
  logic rr_io_q;

  // Context of the transaction currently in flight.
  logic [PA-1:0] cur_addr_q;
  logic          cur_acc_q;
  logic          cur_dirty_q;
  logic          cur_store_q;

  logic          eff_walk;
  logic [PA-1:0] eff_walk_addr;
  logic          eff_mark;
  logic [PA-1:0] eff_mark_addr;
  logic          eff_mark_acc;
  logic          eff_mark_dirty;

  logic          idle;
  logic          grant_mark;
  logic          grant_walk;
  logic          grant_io;
  logic          walk_done;
  logic          io_done;
  logic          mark_rd_done;
  logic          mark_skip;
  logic          mark_wr_issue;
  logic          mark_wr_done;
  logic [63:0]   set_mask;
  logic [63:0]   mark_new;

  logic unused_mark_addr_hi;
  assign unused_mark_addr_hi = ^mark_addr[63:PA];

  // A pulse arriving this cycle is eligible for a grant in the same cycle.
  assign eff_walk       = walk_req_valid | walk_pend_q;
  assign eff_walk_addr  = walk_req_valid ? walk_req_addr : walk_pend_addr_q;
  assign eff_mark       = mark_valid | mark_pend_q;
  assign eff_mark_addr  = mark_valid ? mark_addr[PA-1:0] : mark_pend_addr_q;
  assign eff_mark_acc   = mark_valid ? mark_accessed : mark_pend_acc_q;
  assign eff_mark_dirty = mark_valid ? mark_dirty : mark_pend_dirty_q;

  assign arb_state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_mark)      state_d = S_MARK_RD;
        else if (grant_walk) state_d = S_WALK_RD;
        else if (grant_io)   state_d = S_IO_ACC;
      end
      S_WALK_RD: if (mem_rsp_valid) state_d = S_IDLE;
      S_IO_ACC:  if (mem_rsp_valid) state_d = S_IDLE;
      S_MARK_RD: if (mem_rsp_valid) state_d = mark_skip ? S_IDLE : S_MARK_WR;
      S_MARK_WR: if (mem_rsp_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / decision logic. io handshake: a transfer happens in a cycle where
  // io_req_valid and io_req_ready are both high; ready never waits on anything
  // but the arbiter, and valid must be held with stable payload until then.
  always_comb begin
    idle          = (state_q == S_IDLE) && !reset;
    grant_mark    = idle && eff_mark;
    grant_walk    = idle && !eff_mark && eff_walk && (!io_req_valid || !rr_io_q);
    grant_io      = idle && !eff_mark && io_req_valid && (!eff_walk || rr_io_q);
    io_req_ready  = grant_io;
    walk_done     = (state_q == S_WALK_RD) && mem_rsp_valid;
    io_done       = (state_q == S_IO_ACC)  && mem_rsp_valid;
    mark_rd_done  = (state_q == S_MARK_RD) && mem_rsp_valid;
    mark_wr_done  = (state_q == S_MARK_WR) && mem_rsp_valid;
    // Setting dirty always sets accessed as well.
    set_mask      = ({63'd0, cur_acc_q | cur_dirty_q} << ACC_BIT)
                  | ({63'd0, cur_dirty_q} << DIRTY_BIT);
    mark_new      = mem_rsp_data | set_mask;
    mark_skip     = mark_rd_done && (mark_new == mem_rsp_data);
    mark_wr_issue = mark_rd_done && (mark_new != mem_rsp_data);
  end

  // Pending capture, memory request issue and response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      walk_pend_q       <= 1'b0;
      walk_pend_addr_q  <= '0;
      mark_pend_q       <= 1'b0;
      mark_pend_addr_q  <= '0;
      mark_pend_acc_q   <= 1'b0;
      mark_pend_dirty_q <= 1'b0;
      rr_io_q           <= 1'b0;
      cur_addr_q        <= '0;
      cur_acc_q         <= 1'b0;
      cur_dirty_q       <= 1'b0;
      cur_store_q       <= 1'b0;
      mem_req_valid     <= 1'b0;
      mem_req_addr      <= '0;
      mem_req_store     <= 1'b0;
      mem_req_data      <= '0;
      walk_rsp_valid    <= 1'b0;
      walk_rsp_data     <= '0;
      io_rsp_valid      <= 1'b0;
      io_rsp_data       <= '0;
      mark_rsp_valid    <= 1'b0;
    end else begin
      mem_req_valid  <= 1'b0;
      walk_rsp_valid <= 1'b0;
      io_rsp_valid   <= 1'b0;
      mark_rsp_valid <= 1'b0;

      if (grant_walk) begin
        walk_pend_q <= 1'b0;
      end else if (walk_req_valid) begin
        walk_pend_q      <= 1'b1;
        walk_pend_addr_q <= walk_req_addr;
      end

      if (grant_mark) begin
        mark_pend_q <= 1'b0;
      end else if (mark_valid) begin
        mark_pend_q       <= 1'b1;
        mark_pend_addr_q  <= mark_addr[PA-1:0];
        mark_pend_acc_q   <= mark_accessed;
        mark_pend_dirty_q <= mark_dirty;
      end

      if (grant_mark) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= eff_mark_addr;
        mem_req_store <= 1'b0;
        mem_req_data  <= '0;
        cur_addr_q    <= eff_mark_addr;
        cur_acc_q     <= eff_mark_acc;
        cur_dirty_q   <= eff_mark_dirty;
      end else if (grant_walk) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= eff_walk_addr;
        mem_req_store <= 1'b0;
        mem_req_data  <= '0;
        rr_io_q       <= 1'b1;
      end else if (grant_io) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= io_req_addr;
        mem_req_store <= io_req_store;
        mem_req_data  <= io_req_data;
        cur_store_q   <= io_req_store;
        rr_io_q       <= 1'b0;
      end else if (mark_wr_issue) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= cur_addr_q;
        mem_req_store <= 1'b1;
        mem_req_data  <= mark_new;
      end

      if (walk_done) begin
        walk_rsp_valid <= 1'b1;
        walk_rsp_data  <= mem_rsp_data;
      end
      if (io_done) begin
        io_rsp_valid <= 1'b1;
        io_rsp_data  <= cur_store_q ? 64'd0 : mem_rsp_data;
      end
      if (mark_skip || mark_wr_done) mark_rsp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmu_mem_arb.sv
// Directed bench for mmu_mem_arb: scripted memory responder, response-pulse
// log compared against an expected queue per scenario.
`ifndef PA_WIDTH
`define PA_WIDTH 56
`endif

module tb_mmu_mem_arb;
  localparam int PA = `PA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          walk_req_valid;
  logic [PA-1:0] walk_req_addr;
  logic          walk_rsp_valid;
  logic [63:0]   walk_rsp_data;
  logic          mark_valid;
  logic          mark_accessed;
  logic          mark_dirty;
  logic [63:0]   mark_addr;
  logic          mark_rsp_valid;
  logic          io_req_valid;
  logic          io_req_ready;
  logic          io_req_store;
  logic [PA-1:0] io_req_addr;
  logic [63:0]   io_req_data;
  logic          io_rsp_valid;
  logic [63:0]   io_rsp_data;
  logic          mem_req_valid;
  logic [PA-1:0] mem_req_addr;
  logic          mem_req_store;
  logic [63:0]   mem_req_data;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rsp_data;
  logic [2:0]    arb_state;

  int total = 0;
  int bad   = 0;

  // Log entries: {kind, data}; kind 1 = walk rsp, 2 = io rsp, 3 = mark rsp.
  logic [65:0] log_q[$];
  logic [65:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mmu_mem_arb dut (
    .clk(clk), .reset(reset),
    .walk_req_valid(walk_req_valid), .walk_req_addr(walk_req_addr),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data(walk_rsp_data),
    .mark_valid(mark_valid), .mark_accessed(mark_accessed), .mark_dirty(mark_dirty),
    .mark_addr(mark_addr), .mark_rsp_valid(mark_rsp_valid),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_store(io_req_store),
    .io_req_addr(io_req_addr), .io_req_data(io_req_data),
    .io_rsp_valid(io_rsp_valid), .io_rsp_data(io_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_store(mem_req_store), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .arb_state(arb_state)
  );

  always @(negedge clk) begin
    if (walk_rsp_valid === 1'b1) log_q.push_back({2'd1, walk_rsp_data});
    if (io_rsp_valid === 1'b1)   log_q.push_back({2'd2, io_rsp_data});
    if (mark_rsp_valid === 1'b1) log_q.push_back({2'd3, 64'd0});
  end

  // Driver tasks
  task automatic clear_inputs();
    walk_req_valid = 0; walk_req_addr = '0;
    mark_valid = 0; mark_accessed = 0; mark_dirty = 0; mark_addr = '0;
    io_req_valid = 0; io_req_store = 0; io_req_addr = '0; io_req_data = '0;
    mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_walk(input logic [PA-1:0] a);
    walk_req_valid = 1; walk_req_addr = a;
    @(negedge clk);
    walk_req_valid = 0;
  endtask

  task automatic pulse_mark(input logic [63:0] a, input logic acc, input logic dirty);
    mark_valid = 1; mark_addr = a; mark_accessed = acc; mark_dirty = dirty;
    @(negedge clk);
    mark_valid = 0; mark_accessed = 0; mark_dirty = 0;
  endtask

  // Waits (bounded) for a memory request, then answers after lat cycles.
  task automatic mem_serve(input logic [63:0] rdata, input int lat, output logic got,
                           output logic [PA-1:0] a, output logic st, output logic [63:0] wd);
    got = 0; a = '0; st = 0; wd = '0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req_valid === 1'b1) begin
        got = 1; a = mem_req_addr; st = mem_req_store; wd = mem_req_data;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      repeat (lat) @(negedge clk);
      mem_rsp_valid = 1; mem_rsp_data = rdata;
      @(negedge clk);
      mem_rsp_valid = 0; mem_rsp_data = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    io_req_valid = 1; io_req_addr = PA'(64'h3000);
    walk_req_valid = 1; walk_req_addr = PA'(64'h1000);
    repeat (2) @(negedge clk);
    #1;
    total++; if (arb_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", arb_state); end
    total++; if (io_req_ready !== 1'b0) begin bad++; $display("FAIL reset_io_ready got=%b exp=0", io_req_ready); end
    total++; if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_store !== 1'b0 || mem_req_data !== '0) begin
      bad++; $display("FAIL reset_mem_req got=%b/%h/%b/%h exp=0", mem_req_valid, mem_req_addr, mem_req_store, mem_req_data); end
    total++; if ({walk_rsp_valid, io_rsp_valid, mark_rsp_valid} !== 3'b000 || walk_rsp_data !== '0 || io_rsp_data !== '0) begin
      bad++; $display("FAIL reset_rsp got=%b%b%b exp=000", walk_rsp_valid, io_rsp_valid, mark_rsp_valid); end
    clear_inputs();
    reset = 0;
    log_q.delete();
    repeat (3) @(negedge clk);
    total++; if (arb_state !== 3'd0 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_stale_req state=%0d req=%b exp=0/0", arb_state, mem_req_valid); end
  endtask

  task automatic test_walk();
    do_reset();
    walk_req_valid = 1; walk_req_addr = PA'(64'h1000);
    @(negedge clk);
    walk_req_valid = 0;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== PA'(64'h1000) || mem_req_store !== 1'b0) begin
      bad++; $display("FAIL walk_req got=%b/%h/%b exp=1/1000/0", mem_req_valid, mem_req_addr, mem_req_store); end
    total++; if (arb_state !== 3'd1) begin bad++; $display("FAIL walk_state got=%0d exp=1", arb_state); end
    repeat (3) @(negedge clk);
    total++; if (mem_req_valid !== 1'b0 || walk_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL walk_single_pulse req=%b rsp=%b exp=0/0", mem_req_valid, walk_rsp_valid); end
    mem_rsp_valid = 1; mem_rsp_data = 64'h2000_0001;
    @(negedge clk);
    mem_rsp_valid = 0; mem_rsp_data = '0;
    total++; if (walk_rsp_valid !== 1'b1 || walk_rsp_data !== 64'h2000_0001) begin
      bad++; $display("FAIL walk_rsp got=%b/%h exp=1/20000001", walk_rsp_valid, walk_rsp_data); end
    @(negedge clk);
    total++; if (walk_rsp_valid !== 1'b0 || arb_state !== 3'd0) begin
      bad++; $display("FAIL walk_done rsp=%b state=%0d exp=0/0", walk_rsp_valid, arb_state); end
  endtask

  task automatic test_mark();
    logic got, st;
    logic [PA-1:0] a;
    logic [63:0] wd;
    int reqs;
    do_reset();
    // accessed on 0x0F -> write 0x4F
    pulse_mark(64'h2008, 1'b1, 1'b0);
    mem_serve(64'h0F, 3, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h2008) || st !== 1'b0) begin
      bad++; $display("FAIL mark_acc_read got=%b/%h/%b exp=1/2008/0", got, a, st); end
    mem_serve(64'h0, 2, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h2008) || st !== 1'b1 || wd !== 64'h4F) begin
      bad++; $display("FAIL mark_acc_write got=%b/%h/%b/%h exp=1/2008/1/4f", got, a, st, wd); end
    total++; if (mark_rsp_valid !== 1'b1) begin bad++; $display("FAIL mark_acc_rsp got=%b exp=1", mark_rsp_valid); end
    exp_q.push_back({2'd3, 64'd0});
    // dirty on 0xCF: bits already set, no store
    @(negedge clk);
    pulse_mark(64'h2010, 1'b0, 1'b1);
    mem_serve(64'hCF, 1, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h2010) || st !== 1'b0) begin
      bad++; $display("FAIL mark_dirty_read got=%b/%h/%b exp=1/2010/0", got, a, st); end
    total++; if (mark_rsp_valid !== 1'b1 || arb_state !== 3'd0) begin
      bad++; $display("FAIL mark_skip_rsp rsp=%b state=%0d exp=1/0", mark_rsp_valid, arb_state); end
    exp_q.push_back({2'd3, 64'd0});
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) reqs++;
    end
    total++; if (reqs !== 0) begin bad++; $display("FAIL mark_skip_no_store got=%0d exp=0", reqs); end
    // dirty on 0x00 sets both dirty and accessed
    pulse_mark(64'h2018, 1'b0, 1'b1);
    mem_serve(64'h0, 0, got, a, st, wd);
    mem_serve(64'h0, 0, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h2018) || st !== 1'b1 || wd !== 64'hC0) begin
      bad++; $display("FAIL mark_dirty_write got=%b/%h/%b/%h exp=1/2018/1/c0", got, a, st, wd); end
    exp_q.push_back({2'd3, 64'd0});
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL mark_log_size got=%0d exp=%0d", log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_io_store();
    logic got, st;
    logic [PA-1:0] a;
    logic [63:0] wd;
    do_reset();
    io_req_valid = 1; io_req_store = 1; io_req_addr = PA'(64'h3200); io_req_data = 64'hDEAD;
    #1;
    total++; if (io_req_ready !== 1'b1) begin bad++; $display("FAIL io_store_ready got=%b exp=1", io_req_ready); end
    @(negedge clk);
    io_req_valid = 0; io_req_store = 0;
    mem_serve(64'h99, 1, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h3200) || st !== 1'b1 || wd !== 64'hDEAD) begin
      bad++; $display("FAIL io_store_req got=%b/%h/%b/%h exp=1/3200/1/dead", got, a, st, wd); end
    exp_q.push_back({2'd2, 64'd0});
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL io_store_log_size got=%0d exp=%0d", log_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL io_store_rsp[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic got, st;
    logic [PA-1:0] a;
    logic [63:0] wd;
    logic [PA-1:0] got_a[5];
    logic [PA-1:0] exp_a[5];
    exp_a[0] = PA'(64'h1100); exp_a[1] = PA'(64'h3000); exp_a[2] = PA'(64'h1200);
    exp_a[3] = PA'(64'h3000); exp_a[4] = PA'(64'h1300);
    do_reset();
    io_req_valid = 1; io_req_store = 0; io_req_addr = PA'(64'h3000);
    pulse_walk(PA'(64'h1100));
    mem_serve(64'hA1, 1, got, a, st, wd); got_a[0] = a;
    walk_req_valid = 1; walk_req_addr = PA'(64'h1200);
    #1;
    total++; if (io_req_ready !== 1'b1) begin bad++; $display("FAIL rr_io_turn_ready got=%b exp=1", io_req_ready); end
    @(negedge clk);
    walk_req_valid = 0;
    mem_serve(64'hB1, 1, got, a, st, wd); got_a[1] = a;
    #1;
    total++; if (io_req_ready !== 1'b0) begin bad++; $display("FAIL rr_walk_turn_ready got=%b exp=0", io_req_ready); end
    mem_serve(64'hC1, 1, got, a, st, wd); got_a[2] = a;
    pulse_walk(PA'(64'h1300));
    mem_serve(64'hD1, 1, got, a, st, wd); got_a[3] = a;
    io_req_valid = 0;
    mem_serve(64'hE1, 1, got, a, st, wd); got_a[4] = a;
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rr_timeout got=%b exp=1", got); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%h exp=%h", i, got_a[i], exp_a[i]); end
    end
    exp_q.push_back({2'd1, 64'hA1}); exp_q.push_back({2'd2, 64'hB1});
    exp_q.push_back({2'd1, 64'hC1}); exp_q.push_back({2'd2, 64'hD1});
    exp_q.push_back({2'd1, 64'hE1});
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rr_log_size got=%0d exp=%0d", log_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL rr_rsp[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic got, st;
    logic [PA-1:0] a;
    logic [63:0] wd;
    do_reset();
    io_req_valid = 1; io_req_store = 0; io_req_addr = PA'(64'h3100);
    #1;
    total++; if (io_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_io_ready got=%b exp=1", io_req_ready); end
    @(negedge clk);
    io_req_valid = 0;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== PA'(64'h3100) || mem_req_store !== 1'b0) begin
      bad++; $display("FAIL b2b_io_req got=%b/%h/%b exp=1/3100/0", mem_req_valid, mem_req_addr, mem_req_store); end
    mark_valid = 1; mark_addr = 64'h2020; mark_accessed = 1; mark_dirty = 1;
    walk_req_valid = 1; walk_req_addr = PA'(64'h1400);
    @(negedge clk);
    mark_valid = 0; mark_accessed = 0; mark_dirty = 0; walk_req_valid = 0;
    total++; if (arb_state !== 3'd2) begin bad++; $display("FAIL b2b_io_busy got=%0d exp=2", arb_state); end
    mem_rsp_valid = 1; mem_rsp_data = 64'h77;
    @(negedge clk);
    mem_rsp_valid = 0; mem_rsp_data = '0;
    mem_serve(64'h01, 0, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h2020) || st !== 1'b0) begin
      bad++; $display("FAIL b2b_mark_read got=%b/%h/%b exp=1/2020/0", got, a, st); end
    mem_serve(64'h0, 1, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h2020) || st !== 1'b1 || wd !== 64'hC1) begin
      bad++; $display("FAIL b2b_mark_write got=%b/%h/%b/%h exp=1/2020/1/c1", got, a, st, wd); end
    mem_serve(64'h55, 0, got, a, st, wd);
    total++; if (got !== 1'b1 || a !== PA'(64'h1400) || st !== 1'b0) begin
      bad++; $display("FAIL b2b_walk_read got=%b/%h/%b exp=1/1400/0", got, a, st); end
    exp_q.push_back({2'd2, 64'h77}); exp_q.push_back({2'd3, 64'd0}); exp_q.push_back({2'd1, 64'h55});
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_log_size got=%0d exp=%0d", log_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic got, st;
    logic [PA-1:0] a;
    logic [63:0] wd;
    int pulses;
    do_reset();
    pulse_mark(64'h2030, 1'b1, 1'b0);
    mem_serve(64'h0, 0, got, a, st, wd);
    total++; if (arb_state !== 3'd4 || mem_req_valid !== 1'b1 || mem_req_store !== 1'b1) begin
      bad++; $display("FAIL mid_in_mark_wr state=%0d req=%b st=%b exp=4/1/1", arb_state, mem_req_valid, mem_req_store); end
    reset = 1;
    @(negedge clk);
    #1;
    total++; if (arb_state !== 3'd0 || mem_req_valid !== 1'b0 || mark_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs state=%0d req=%b mrsp=%b exp=0/0/0", arb_state, mem_req_valid, mark_rsp_valid); end
    reset = 0;
    mem_rsp_valid = 1; mem_rsp_data = 64'hFF;
    @(negedge clk);
    mem_rsp_valid = 0; mem_rsp_data = '0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (mark_rsp_valid === 1'b1 || mem_req_valid === 1'b1 || walk_rsp_valid === 1'b1 || io_rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_stray_rsp got=%0d exp=0", pulses); end
    total++; if (arb_state !== 3'd0) begin bad++; $display("FAIL mid_final_state got=%0d exp=0", arb_state); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_walk();
    test_mark();
    test_io_store();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
